// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable symbol pattern detector.
// Holds the FSM state encoding and the length-field width calculation.
package seq_det_pkg;

  typedef enum logic [1:0] {
    UNCFG   = 2'd0,
    HUNT    = 2'd1,
    MATCHED = 2'd2
  } state_t;

  // Width needed to hold a pattern length of 0..max_len.
  function automatic int calc_len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/seq_hist_shift.sv
// Symbol history window, fill counter and masked pattern compare for the detector.
// hit_next is combinational on the accepted symbol; history updates at the clock edge, no backpressure.
module seq_hist_shift
  import seq_det_pkg::*;
#(
  parameter int SYM_W   = 2,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_shift,
  input  logic [SYM_W-1:0]         i_sym,
  input  logic [LEN_W-1:0]         i_len,
  input  logic [MAX_LEN*SYM_W-1:0] i_pattern,
  input  logic                     i_overlap,
  output logic                     o_hit_next
);

  // The incoming symbol is always the newest window slot, so only MAX_LEN-1 are stored.
  localparam int HIST_D = (MAX_LEN > 1) ? MAX_LEN - 1 : 1;

  logic [SYM_W-1:0] r_hist [HIST_D];
  logic [SYM_W-1:0] w_hist_next [MAX_LEN];
  logic [SYM_W-1:0] w_pat [MAX_LEN];
  logic [LEN_W-1:0] r_fill;
  logic [LEN_W:0]   w_fill_inc;
  logic             w_len_ok;
  logic             w_full;
  logic             w_all_eq;

  assign w_fill_inc = {1'b0, r_fill} + {{LEN_W{1'b0}}, 1'b1};
  assign w_full     = (w_fill_inc >= {1'b0, i_len});
  assign w_len_ok   = (i_len != '0) && (i_len <= LEN_W'(MAX_LEN));

  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      w_pat[i] = i_pattern[i*SYM_W +: SYM_W];
    end
  end

  always_comb begin
    w_hist_next[0] = i_sym;
    for (int i = 1; i < MAX_LEN; i++) begin
      w_hist_next[i] = r_hist[i-1];
    end
  end

  // Slot i (0 = newest) must equal pattern symbol len-1-i; slots at or beyond len are ignored.
  always_comb begin
    w_all_eq = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        if ((i + k + 1) == int'(i_len) && w_hist_next[i] != w_pat[k]) begin
          w_all_eq = 1'b0;
        end
      end
    end
  end

  assign o_hit_next = i_shift & w_len_ok & w_full & w_all_eq;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      for (int i = 0; i < HIST_D; i++) begin
        r_hist[i] <= '0;
      end
      r_fill <= '0;
    end else if (i_shift) begin
      for (int i = 0; i < HIST_D; i++) begin
        r_hist[i] <= w_hist_next[i];
      end
      if (o_hit_next && !i_overlap) begin
        r_fill <= '0;
      end else if (w_fill_inc <= {1'b0, i_len}) begin
        r_fill <= w_fill_inc[LEN_W-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Run-time programmable symbol pattern detector with match pulse, sticky hold and saturating count.
// match follows the completing symbol by one cycle; the symbol stream is never backpressured.
module seq_pattern_detector
  import seq_det_pkg::*;
#(
  parameter  int SYM_W   = 2,
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 16,
  localparam int LEN_W   = calc_len_w(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [SYM_W-1:0]         in_sym,
  input  logic                     cfg_we,
  input  logic [LEN_W-1:0]         cfg_len,
  input  logic [MAX_LEN*SYM_W-1:0] cfg_pattern,
  input  logic                     cfg_idle_en,
  input  logic [SYM_W-1:0]         cfg_idle_sym,
  input  logic                     cfg_overlap,
  output logic                     match,
  output logic                     hold,
  output logic [CNT_W-1:0]         match_cnt
);

  logic [LEN_W-1:0]         r_len;
  logic [MAX_LEN*SYM_W-1:0] r_pattern;
  logic                     r_idle_en;
  logic [SYM_W-1:0]         r_idle_sym;
  logic                     r_overlap;
  state_t                   r_state;
  state_t                   w_state_next;
  logic                     r_match;
  logic [CNT_W-1:0]         r_cnt;
  logic                     w_cfg_len_ok;
  logic                     w_accept;
  logic                     w_hit;
  logic [SYM_W-1:0]         w_last_sym;

  assign w_cfg_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  // A config write in the same cycle drops the symbol.
  assign w_accept = in_valid & ~cfg_we & (r_state != UNCFG)
                  & ~(r_idle_en & (in_sym == r_idle_sym));

  always_comb begin
    w_last_sym = '0;
    for (int k = 0; k < MAX_LEN; k++) begin
      if ((k + 1) == int'(r_len)) begin
        w_last_sym = r_pattern[k*SYM_W +: SYM_W];
      end
    end
  end

  seq_hist_shift #(
    .SYM_W   (SYM_W),
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_hist (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (cfg_we),
    .i_shift    (w_accept),
    .i_sym      (in_sym),
    .i_len      (r_len),
    .i_pattern  (r_pattern),
    .i_overlap  (r_overlap),
    .o_hit_next (w_hit)
  );

  always_comb begin
    w_state_next = r_state;
    if (cfg_we) begin
      w_state_next = w_cfg_len_ok ? HUNT : UNCFG;
    end else begin
      case (r_state)
        UNCFG:   w_state_next = UNCFG;
        HUNT:    if (w_hit) w_state_next = MATCHED;
        MATCHED: if (w_accept && !w_hit && (in_sym != w_last_sym)) w_state_next = HUNT;
        default: w_state_next = UNCFG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= UNCFG;
      r_len      <= '0;
      r_pattern  <= '0;
      r_idle_en  <= 1'b0;
      r_idle_sym <= '0;
      r_overlap  <= 1'b0;
      r_match    <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_next;
      r_match <= w_hit;
      if (cfg_we) begin
        r_len      <= cfg_len;
        r_pattern  <= cfg_pattern;
        r_idle_en  <= cfg_idle_en;
        r_idle_sym <= cfg_idle_sym;
        r_overlap  <= cfg_overlap;
      end
      if (w_hit && !(&r_cnt)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign match     = r_match;
  assign hold      = (r_state == MATCHED);
  assign match_cnt = r_cnt;

endmodule
